// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types, constants and round-robin search helper for rr_mux4_stage
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam int   NUM_SRC   = 4;
  localparam sel_t RESET_PTR = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Result of a round-robin search: whether any source requested, and which one won.
  typedef struct packed {
    logic found;
    sel_t idx;
  } pick_t;

  // Scan the request vector starting one past the last winner, wrapping through
  // all sources; the first requester found wins.
  function automatic pick_t rr_pick(input sel_t last, input logic [NUM_SRC-1:0] req);
    pick_t res;
    sel_t  cand;
    res.found = 1'b0;
    res.idx   = last;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = last + sel_t'(k);
      if (req[cand] && !res.found) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4a1wN.sv
// rtl/mux4a1wN.sv - plain 4:1 N-bit combinational multiplexer
module mux4a1wN #(
  parameter int N = 4
) (
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  input  logic [1:0]   sel,
  output logic [N-1:0] out
);

  // Select one of the four words by index.
  always_comb begin
    out = d0;
    case (sel)
      2'd0:    out = d0;
      2'd1:    out = d1;
      2'd2:    out = d2;
      default: out = d3;
    endcase
  end

endmodule

// File: rtl/rr_mux4_stage.sv
// rtl/rr_mux4_stage.sv - round-robin arbiter driving a 4:1 mux into a one-entry output buffer
module rr_mux4_stage
  import mux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  output logic [1:0]   sel,
  output logic [N-1:0] out_data,
  output logic [1:0]   out_src,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t       state_q, state_d;
  sel_t         last_grant_q, last_grant_d;
  sel_t         sel_q, sel_d;
  logic [N-1:0] out_data_q, out_data_d;
  sel_t         out_src_q, out_src_d;

  pick_t        pick;
  logic         load_en;
  logic         xfer;
  sel_t         sel_int;
  logic [N-1:0] mux_out;

  // The buffer can take a word when empty, or when its current word leaves this cycle.
  always_comb begin
    load_en = (state_q == EMPTY) | ((state_q == FULL) & out_ready);
  end

  // Round-robin search from the last winner; a transfer happens whenever any
  // source requests while the buffer can load.
  always_comb begin
    pick = rr_pick(last_grant_q, in_valid);
    xfer = pick.found & load_en;
  end

  // Grant index steers the mux only while a transfer is happening; otherwise
  // the select rests on the previous grant (zero straight out of reset).
  always_comb begin
    sel_int = sel_q;
    if (xfer) begin
      sel_int = pick.idx;
    end
  end

  // Only the winner sees ready, and only when it is actually moving a word.
  always_comb begin
    in_ready = 4'b0000;
    if (xfer) begin
      in_ready[pick.idx] = 1'b1;
    end
  end

  mux4a1wN #(.N(N)) u_mux (
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .sel (sel_int),
    .out (mux_out)
  );

  // Buffer occupancy: load keeps or makes it FULL, consume without refill empties it.
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = FULL;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Datapath next state: capture the muxed word, its source and the new priority pointer.
  always_comb begin
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    if (xfer) begin
      last_grant_d = pick.idx;
      sel_d        = pick.idx;
      out_data_d   = mux_out;
      out_src_d    = pick.idx;
    end
  end

  // Occupancy register; reset drops any held word immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output buffer, source tag and arbitration pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= RESET_PTR;
      sel_q        <= 2'd0;
      out_data_q   <= '0;
      out_src_q    <= 2'd0;
    end else begin
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
    end
  end

  assign sel       = sel_int;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = (state_q == FULL);

  // A source is never told ready unless it is requesting, and at most one at a time.
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_ready_valid:  assert property (@(posedge clk) disable iff (rst) (in_ready & ~in_valid) == 4'b0000);

endmodule

// File: tb/tb_rr_mux4_stage.sv
// tb/tb_rr_mux4_stage.sv - directed self-checking bench for rr_mux4_stage
module tb_rr_mux4_stage;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [N-1:0] d0, d1, d2, d3;
  logic [1:0]   sel;
  logic [N-1:0] out_data;
  logic [1:0]   out_src;
  logic         out_valid;
  logic         out_ready;

  int n_cmp;
  int n_bad;

  rr_mux4_stage #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .sel       (sel),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic [3:0] exp_src_seq [6];
  logic [3:0] exp_dat_seq [6];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    in_valid = 4'b0000;
    out_ready = 1'b1;
    d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;

    // 1: reset then idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      check("idle_valid", 32'(out_valid), 32'h0);
      check("idle_data",  32'(out_data),  32'h0);
      check("idle_ready", 32'(in_ready),  32'h0);
      check("idle_sel",   32'(sel),       32'h0);
      tick();
    end

    // 2: single request from source 2
    d2 = 4'h7;
    in_valid = 4'b0100;
    #1;
    check("s2_ready", 32'(in_ready), 32'h4);
    check("s2_sel",   32'(sel),      32'h2);
    tick();
    in_valid = 4'b0000;
    #1;
    check("s2_valid", 32'(out_valid), 32'h1);
    check("s2_data",  32'(out_data),  32'h7);
    check("s2_src",   32'(out_src),   32'h2);
    tick();
    check("s2_drop",  32'(out_valid), 32'h0);
    check("s2_hold",  32'(out_data),  32'h7);

    // 3: full contention from a fresh pointer
    d0 = 4'h8; d1 = 4'h3; d2 = 4'h7; d3 = 4'hF;
    do_reset();
    exp_src_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
    exp_dat_seq = '{4'h8, 4'h3, 4'h7, 4'hF, 4'h8, 4'h3};
    in_valid = 4'b1111;
    #1;
    check("s3_first_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("s3_valid", 32'(out_valid), 32'h1);
      check("s3_src",   32'(out_src),   32'(exp_src_seq[i]));
      check("s3_data",  32'(out_data),  32'(exp_dat_seq[i]));
    end
    in_valid = 4'b0000;
    tick();
    check("s3_empty", 32'(out_valid), 32'h0);

    // 4: backpressure after the first word
    do_reset();
    in_valid = 4'b1111;
    tick();
    check("s4_first", 32'(out_data), 32'h8);
    out_ready = 1'b0;
    #1;
    check("s4_stall_ready0", 32'(in_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s4_stall_data",  32'(out_data),  32'h8);
      check("s4_stall_src",   32'(out_src),   32'h0);
      check("s4_stall_valid", 32'(out_valid), 32'h1);
      check("s4_stall_ready", 32'(in_ready),  32'h0);
      check("s4_stall_sel",   32'(sel),       32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("s4_resume_ready", 32'(in_ready), 32'h2);
    tick();
    check("s4_next_data", 32'(out_data), 32'h3);
    check("s4_next_src",  32'(out_src),  32'h1);
    in_valid = 4'b0000;
    tick();
    check("s4_empty", 32'(out_valid), 32'h0);

    // 5: wrap priority after source 3 wins
    do_reset();
    in_valid = 4'b1000;
    tick();
    check("s5_pre_src", 32'(out_src), 32'h3);
    in_valid = 4'b1001;
    #1;
    check("s5_ready0", 32'(in_ready), 32'h1);
    tick();
    check("s5_src0",   32'(out_src),  32'h0);
    check("s5_data0",  32'(out_data), 32'h8);
    check("s5_ready3", 32'(in_ready), 32'h8);
    tick();
    check("s5_src3",   32'(out_src),  32'h3);
    check("s5_data3",  32'(out_data), 32'hF);
    in_valid = 4'b0000;
    tick();
    check("s5_empty", 32'(out_valid), 32'h0);

    // 6: asynchronous reset while FULL
    do_reset();
    in_valid = 4'b1000;
    tick();
    in_valid = 4'b0000;
    out_ready = 1'b0;
    #1;
    check("s6_full", 32'(out_valid), 32'h1);
    check("s6_data", 32'(out_data),  32'hF);
    rst = 1'b1;
    #1;
    check("s6_rst_valid", 32'(out_valid), 32'h0);
    check("s6_rst_data",  32'(out_data),  32'h0);
    check("s6_rst_src",   32'(out_src),   32'h0);
    tick();
    rst = 1'b0;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("s6_ready", 32'(in_ready), 32'h1);
    check("s6_sel",   32'(sel),      32'h0);
    tick();
    check("s6_src",  32'(out_src),  32'h0);
    check("s6_data2", 32'(out_data), 32'h8);
    in_valid = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
